// File: rtl/xor_fold_ctrl.sv
// Folds a programmed number of words into one accumulator through a shared XOR_N,
// then holds the result and its parity until the consumer acknowledges it.

module XOR_N #(
  parameter int N = 64
) (
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  output logic [N-1:0] Y_o
);
  assign Y_o = A_i ^ B_i;
endmodule

module xor_fold_ctrl #(
  parameter int REGISTER_LENGTH = 64,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       start_i,
  input  logic [COUNT_WIDTH-1:0]     count_i,
  input  logic [REGISTER_LENGTH-1:0] seed_i,
  input  logic [REGISTER_LENGTH-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [REGISTER_LENGTH-1:0] result_o,
  output logic                       parity_o,
  output logic                       done_o,
  input  logic                       ack_i,
  output logic                       busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                     state_q;
  logic [REGISTER_LENGTH-1:0] acc_q;
  logic [REGISTER_LENGTH-1:0] acc_d;
  logic [COUNT_WIDTH-1:0]     remaining_q;

  // The only datapath XOR: next accumulator value for an ACCUM beat.
  XOR_N #(REGISTER_LENGTH) u_xor (
    .A_i (acc_q),
    .B_i (data_i),
    .Y_o (acc_d)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q       <= seed_i;
            remaining_q <= count_i;
            state_q     <= (count_i == '0) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          // ready_o is 1 throughout ACCUM, so valid_i alone marks a beat.
          if (valid_i) begin
            acc_q       <= acc_d;
            remaining_q <= remaining_q - COUNT_WIDTH'(1);
            if (remaining_q == COUNT_WIDTH'(1)) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (ack_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = acc_q;
  assign parity_o = ^acc_q;
  assign ready_o  = (state_q == ACCUM);
  assign done_o   = (state_q == HOLD);
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_xor_fold_ctrl.sv
// Bench for xor_fold_ctrl: directed scenarios plus randomized folds against a
// word-list model (result = seed XOR every accepted word, done after N accepts).

module tb_xor_fold_ctrl;
  localparam int RL = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [RL-1:0] seed = '0;
  logic [RL-1:0] data = '0;
  logic          valid = 1'b0;
  logic          ack = 1'b0;
  logic          ready;
  logic [RL-1:0] result;
  logic          parity;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_fold_ctrl #(.REGISTER_LENGTH(RL), .COUNT_WIDTH(CW)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start),
    .count_i   (count),
    .seed_i    (seed),
    .data_i    (data),
    .valid_i   (valid),
    .ready_o   (ready),
    .result_o  (result),
    .parity_o  (parity),
    .done_o    (done),
    .ack_i     (ack),
    .busy_o    (busy)
  );

  function automatic logic [RL-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic par_of(input logic [RL-1:0] v);
    return logic'($countones(v) % 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; valid = 1'b0; ack = 1'b0; count = '0; seed = '0; data = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom()); valid = 1'($urandom()); ack = 1'($urandom());
      count = CW'($urandom()); seed = rnd64(); data = rnd64();
      tick();
    end
    checks++;
    if ({ready, done, busy, parity} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/done/busy/par=%b required 0000", {ready, done, busy, parity});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h required 0", result);
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_continuous();
    logic [RL-1:0] words [3];
    words[0] = 64'h1; words[1] = 64'h2; words[2] = 64'h4;
    seed = '0; count = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, ready, done} !== 3'b110) begin
      errors++;
      $display("FAIL cont_start: got busy/rdy/done=%b required 110", {busy, ready, done});
    end
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; data = words[i];
      tick();
      checks++;
      if (done !== (i == 2)) begin
        errors++;
        $display("FAIL cont_done_beat%0d: got %b required %b", i, done, (i == 2));
      end
    end
    valid = 1'b0;
    checks++;
    if (result !== 64'h7 || parity !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL cont_result: got res=%h par=%b rdy=%b required res=7 par=1 rdy=0", result, parity, ready);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL cont_ack: got done/busy=%b required 00", {done, busy});
    end
  endtask

  task automatic test_stalled();
    seed = '1; count = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1; data = 64'h1;
    tick();
    valid = 1'b0; data = rnd64();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (result !== 64'hFFFF_FFFF_FFFF_FFFE || ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_gap%0d: got res=%h rdy=%b done=%b required res=fffffffffffffffe rdy=1 done=0",
                 i, result, ready, done);
      end
    end
    valid = 1'b1; data = '1;
    tick();
    valid = 1'b0;
    checks++;
    if (result !== 64'h1 || parity !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL stall_result: got res=%h par=%b done=%b required res=1 par=1 done=1", result, parity, done);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_zero_count();
    seed = 64'hA5; count = '0; start = 1'b1; valid = 1'b1; data = rnd64();
    tick();
    start = 1'b0; valid = 1'b0;
    checks++;
    if (done !== 1'b1 || ready !== 1'b0 || result !== 64'hA5 || parity !== 1'b0) begin
      errors++;
      $display("FAIL zero_count: got done=%b rdy=%b res=%h par=%b required done=1 rdy=0 res=a5 par=0",
               done, ready, result, parity);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_ack: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_hold_ack();
    logic [RL-1:0] s, w, exp;
    s = rnd64(); w = rnd64(); exp = s ^ w;
    seed = s; count = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; valid = 1'b1; data = w;
    tick();
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; valid = 1'b1; data = rnd64(); seed = rnd64(); count = CW'($urandom_range(1, 200));
      tick();
      checks++;
      if (result !== exp || done !== 1'b1 || ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got res=%h done=%b rdy=%b required res=%h done=1 rdy=0",
                 i, result, done, ready, exp);
      end
    end
    ack = 1'b1;
    tick();
    checks++;
    if ({done, busy, ready} !== 3'b000) begin
      errors++;
      $display("FAIL hold_ack: got done/busy/rdy=%b required 000", {done, busy, ready});
    end
    idle_inputs();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_no_restart: got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid_fold();
    seed = '0; count = 8'd4; start = 1'b1;
    tick();
    start = 1'b0; valid = 1'b1; data = 64'h3;
    tick();
    valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || result !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got busy=%b res=%h rdy=%b required busy=0 res=0 rdy=0", busy, result, ready);
    end
    seed = '0; count = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; valid = 1'b1; data = 64'h8;
    tick();
    valid = 1'b0;
    checks++;
    if (result !== 64'h8 || done !== 1'b1) begin
      errors++;
      $display("FAIL midreset_refold: got res=%h done=%b required res=8 done=1", result, done);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // One fold against the model: the model counts its own accepted words and
  // predicts ready/done from that count alone.
  task automatic run_random_fold(input int n, input int valid_pct);
    logic [RL-1:0] s, exp;
    int accepted, cycles;
    s = rnd64(); exp = s; accepted = 0; cycles = 0;
    seed = s; count = CW'(n); start = 1'b1;
    tick();
    idle_inputs();
    while (accepted < n && cycles < 4000) begin
      valid = ($urandom_range(0, 99) < valid_pct);
      data = rnd64();
      checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL rand_accum n=%0d acc=%0d: got rdy=%b done=%b required rdy=1 done=0", n, accepted, ready, done);
      end
      if (valid) begin
        exp = exp ^ data;
        accepted++;
      end
      tick();
      cycles++;
    end
    valid = 1'b0;
    checks++;
    if (accepted != n) begin
      errors++;
      $display("FAIL rand_timeout n=%0d: got %0d accepted required %0d", n, accepted, n);
    end
    for (int g = $urandom_range(0, 3); g >= 0; g--) begin
      checks++;
      if (done !== 1'b1 || ready !== 1'b0 || result !== exp || parity !== par_of(exp)) begin
        errors++;
        $display("FAIL rand_hold n=%0d: got done=%b rdy=%b res=%h par=%b required done=1 rdy=0 res=%h par=%b",
                 n, done, ready, result, parity, exp, par_of(exp));
      end
      ack = (g == 0);
      tick();
    end
    ack = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rand_ack n=%0d: got busy=%b required 0", n, busy);
    end
  endtask

  task automatic test_random_folds();
    for (int t = 0; t < 20; t++) begin
      run_random_fold($urandom_range(0, 12), 60);
    end
    run_random_fold(255, 100);
    run_random_fold(255, 70);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_stalled();
    test_zero_count();
    test_hold_ack();
    test_reset_mid_fold();
    test_random_folds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
